// File: rtl/enc_disp_ctrl.sv
// rtl/enc_disp_ctrl.sv - 8b/10b encoder front stage: running disparity and sub-block control
module enc_disp_ctrl #(
    parameter logic RD_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_k,
    input  logic       rd_force,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] data_5b,
    output logic       compls6,
    output logic [4:0] data_buffer,
    output logic       compls4,
    output logic       rd_out,
    output logic       kerr
);

    logic       rd_q;
    logic       xfer;
    logic [4:0] x;
    logic       f, g, h;
    logic       k_legal, k_eff, kerr_d;
    logic       rd_cur, alt6, rd6;
    logic       nd, pd, s_bit;
    logic       compls6_d, compls4_d, rd_new;

    assign in_ready = ~out_valid | out_ready;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        x = in_data[4:0];
        f = in_data[5];
        g = in_data[6];
        h = in_data[7];

        // K28.y for any y, plus the four Kx.7 codes with a unique comma-free pattern
        k_legal = (x == 5'd28) || (in_data == 8'hF7) || (in_data == 8'hFB) ||
                  (in_data == 8'hFD) || (in_data == 8'hFE);
        k_eff   = in_k & k_legal;
        kerr_d  = in_k & ~k_legal;

        rd_cur = rd_force ? RD_INIT : rd_q;

        alt6 = 1'b0;
        case (x)
            5'd0, 5'd1, 5'd2, 5'd4, 5'd7, 5'd8, 5'd15, 5'd16,
            5'd23, 5'd24, 5'd27, 5'd29, 5'd30, 5'd31: alt6 = 1'b1;
            5'd28:                                    alt6 = k_eff;
            default:                                  alt6 = 1'b0;
        endcase

        compls6_d = alt6 & rd_cur;
        // D.07 is balanced in both forms, so it never flips disparity
        rd6       = rd_cur ^ (alt6 & (x != 5'd7));

        nd        = f & g;
        pd        = (~f & ~g) | (k_eff & (f ^ g));
        compls4_d = (pd & ~rd6) | (nd & rd6);

        // Alternate D.x.A7 avoids a run of five identical bits across the sub-block boundary
        s_bit = f & g & h &
                ((~rd6 & ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) |
                 ( rd6 & ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));

        rd_new = rd6 ^ ((~f & ~g) | (f & g & h));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= RD_INIT;
            out_valid   <= 1'b0;
            data_5b     <= 5'd0;
            compls6     <= 1'b0;
            data_buffer <= 5'd0;
            compls4     <= 1'b0;
            rd_out      <= RD_INIT;
            kerr        <= 1'b0;
        end else if (xfer) begin
            rd_q        <= rd_new;
            out_valid   <= 1'b1;
            data_5b     <= x;
            compls6     <= compls6_d;
            data_buffer <= {s_bit, k_eff, h, g, f};
            compls4     <= compls4_d;
            rd_out      <= rd_new;
            kerr        <= kerr_d;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (rd_force) begin
                rd_q <= RD_INIT;
            end
        end
    end

endmodule

// File: tb/tb_enc_disp_ctrl.sv
// tb/tb_enc_disp_ctrl.sv - randomized and directed check of enc_disp_ctrl against a behavioural model
module tb_enc_disp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_k = 1'b0;
    logic       rd_force = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] data_5b;
    logic       compls6;
    logic [4:0] data_buffer;
    logic       compls4;
    logic       rd_out;
    logic       kerr;

    int tests = 0;
    int fails = 0;

    enc_disp_ctrl #(.RD_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_k(in_k),
        .rd_force(rd_force),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_5b(data_5b), .compls6(compls6), .data_buffer(data_buffer), .compls4(compls4),
        .rd_out(rd_out), .kerr(kerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model result packing: {data_5b, compls6, data_buffer, compls4, new_rd, kerr}
    function automatic logic [13:0] m_enc(input logic [7:0] b, input logic k, input logic rd);
        int  x, y;
        bit  kk, ke, alt, r6, f, g, h, nd, pd, c4, s, rn;
        x  = int'(b[4:0]);
        y  = int'(b[7:5]);
        f  = b[5]; g = b[6]; h = b[7];
        kk = k && (x == 28 || b inside {8'hF7, 8'hFB, 8'hFD, 8'hFE});
        ke = k && !kk;
        alt = (x inside {0, 1, 2, 4, 7, 8, 15, 16, 23, 24, 27, 29, 30, 31}) || (kk && x == 28);
        r6 = alt && x != 7 ? !rd : rd;
        nd = f && g;
        pd = (!f && !g) || (kk && f != g);
        c4 = r6 ? nd : pd;
        s  = (y == 7) && (r6 ? (x inside {11, 13, 14}) : (x inside {17, 18, 20}));
        rn = (y inside {0, 4, 7}) ? !r6 : r6;
        return {b[4:0], alt && rd, s, kk, h, g, f, c4, rn, ke};
    endfunction

    logic       m_valid, m_rd, m_c6, m_c4, m_rdout, m_kerr;
    logic [4:0] m_5b, m_buf;

    always @(negedge clk) begin
        logic [13:0] e;
        if (!rst_n) begin
            m_valid = 0; m_rd = 0; m_c6 = 0; m_c4 = 0; m_rdout = 0; m_kerr = 0;
            m_5b = 0; m_buf = 0;
            chk("rst_data_5b", data_5b, 0);
            chk("rst_data_buffer", data_buffer, 0);
        end
        chk("out_valid", out_valid, m_valid);
        chk("rd_out", rd_out, m_rdout);
        chk("in_ready", in_ready, !m_valid || out_ready);
        if (m_valid) begin
            chk("data_5b", data_5b, m_5b);
            chk("compls6", compls6, m_c6);
            chk("data_buffer", data_buffer, m_buf);
            chk("compls4", compls4, m_c4);
            chk("kerr", kerr, m_kerr);
        end
        if (rst_n) begin
            if (in_valid && (!m_valid || out_ready)) begin
                e = m_enc(in_data, in_k, rd_force ? 1'b0 : m_rd);
                {m_5b, m_c6, m_buf, m_c4, m_rdout, m_kerr} = e;
                m_rd = m_rdout;
                m_valid = 1;
            end else begin
                if (out_ready) m_valid = 0;
                if (rd_force) m_rd = 0;
            end
        end
    end

    task automatic cycle(input logic v, input logic [7:0] d, input logic k,
                         input logic ordy, input logic frc);
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; in_k = k; out_ready = ordy; rd_force = frc;
    endtask

    // Returns one step after the transfer edge, outputs showing the encoded word
    task automatic send(input logic [7:0] d, input logic k);
        cycle(1, d, k, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);
        #1;
    endtask

    logic [4:0] hold_5b;
    logic       hold_rd;

    initial begin
        chk("model_k28_5_rdm", m_enc(8'hBC, 1, 0), {5'b11100, 1'b0, 5'b01101, 1'b0, 1'b1, 1'b0});
        chk("model_k28_5_rdp", m_enc(8'hBC, 1, 1), {5'b11100, 1'b1, 5'b01101, 1'b1, 1'b0, 1'b0});
        chk("model_d0_0_rdm",  m_enc(8'h00, 0, 0), {5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0});
        chk("model_d17_7_rdm", m_enc(8'hF1, 0, 0), {5'b10001, 1'b0, 5'b10111, 1'b0, 1'b1, 1'b0});
        chk("model_d17_7_rdp", m_enc(8'hF1, 0, 1), {5'b10001, 1'b0, 5'b00111, 1'b1, 1'b0, 1'b0});
        chk("model_badk",      m_enc(8'h00, 1, 0), {5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1});

        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_rd_out", rd_out, 0);
        @(posedge clk); #1 rst_n = 1;

        send(8'hBC, 1);
        chk("t1_data_5b", data_5b, 5'b11100);
        chk("t1_buf", data_buffer, 5'b01101);
        chk("t1_c6", compls6, 0);
        chk("t1_c4", compls4, 0);
        chk("t1_rd", rd_out, 1);
        send(8'hBC, 1);
        chk("t1b_c6", compls6, 1);
        chk("t1b_c4", compls4, 1);
        chk("t1b_rd", rd_out, 0);

        send(8'h00, 0);
        chk("t2_c6", compls6, 0);
        chk("t2_c4", compls4, 0);
        chk("t2_rd", rd_out, 0);
        send(8'hF1, 0);
        chk("t2b_buf", data_buffer, 5'b10111);
        chk("t2b_c4", compls4, 0);
        chk("t2b_rd", rd_out, 1);

        send(8'hF1, 0);
        chk("t3_S", data_buffer[4], 0);
        chk("t3_c6", compls6, 0);
        chk("t3_c4", compls4, 1);
        chk("t3_rd", rd_out, 0);
        send(8'hBC, 1);
        send(8'hEB, 0);
        chk("t3b_S", data_buffer[4], 1);

        cycle(1, 8'h55, 0, 1, 0);
        cycle(1, 8'h66, 0, 0, 0);
        #1;
        hold_5b = data_5b;
        hold_rd = rd_out;
        chk("t4_first_word", hold_5b, 5'h15);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'h66, 0, 0, 0);
            #1;
            chk("t4_in_ready", in_ready, 0);
            chk("t4_hold_5b", data_5b, hold_5b);
            chk("t4_hold_rd", rd_out, hold_rd);
        end
        for (int i = 0; i < 6; i++) cycle(1, 8'(8'h70 + i), 0, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);

        cycle(0, 8'h00, 0, 1, 1);
        send(8'h00, 1);
        chk("t5_kerr", kerr, 1);
        chk("t5_buf", data_buffer, 5'b00000);
        chk("t5_c6", compls6, 0);
        chk("t5_rd", rd_out, 0);
        send(8'hFC, 1);
        chk("t5b_kerr", kerr, 0);
        chk("t5b_buf", data_buffer, 5'b01111);

        cycle(0, 8'h00, 0, 1, 1);
        send(8'hBC, 1);
        chk("t6_rdp", rd_out, 1);
        cycle(0, 8'h00, 0, 1, 1);
        cycle(0, 8'h00, 0, 1, 0);
        #1;
        chk("t6_rd_hold", rd_out, 1);
        send(8'hBC, 1);
        chk("t6_c6", compls6, 0);

        cycle(1, 8'hBC, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        #1;
        chk("t6_pre_valid", out_valid, 1);
        rst_n = 0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_rd", rd_out, 0);
        @(posedge clk); #1 rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            logic       k;
            k = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       d = {3'($urandom), 5'd28};
                1:       d = 8'hF0 | 8'($urandom_range(0, 15));
                default: d = 8'($urandom);
            endcase
            cycle($urandom_range(0, 9) < 7, d, k, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 15) == 0);
        end
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
